// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns and BCD-to-segment decode for the scan driver
package seg7_pkg;

  // Active-low patterns, bit6..bit0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational 4-bit BCD to active-low 7-segment decoder
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 7-segment scan driver with blanking gap
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   BCD_IN,
  input  logic                  BLANK_LZ,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  DIGIT_TICK
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  terminal;
  logic [3:0]            digit [DIGITS];
  logic [DIGITS-1:0]     lead_zero;
  logic                  all_zero;
  logic [3:0]            sel_digit;
  logic [6:0]            dec_seg;
  logic                  blank_sel;

  always_comb begin
    terminal = (pcnt_q == PTERM);
    pcnt_d   = terminal ? '0 : pcnt_q + 1'b1;
    idx_d    = idx_q;
    if (terminal) begin
      idx_d = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
    end
    tick_d   = terminal;
    shadow_d = LOAD ? BCD_IN : shadow_q;
  end

  // lead_zero[k]: digit k and every digit above it are exactly zero
  always_comb begin
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit[k]     = shadow_q[4*k +: 4];
      all_zero     = all_zero & (shadow_q[4*k +: 4] == 4'd0);
      lead_zero[k] = all_zero;
    end
  end

  // Outputs are registered, so they are computed from the next-cycle scan position
  assign sel_digit = digit[idx_d];
  assign blank_sel = BLANK_LZ && (idx_d != '0) && lead_zero[idx_d];

  bcd_to_seg7 u_dec (
    .bcd_i (sel_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = blank_sel ? SEG_BLANK : dec_seg;
    an_d  = '1;
    if (!tick_d) begin
      an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign DIGIT_TICK = tick_q;

endmodule
